// File: rtl/elevator_ctrl.sv
// Four-floor elevator controller: FIFO request queue of up to four floors,
// serviced strictly in arrival order with timed travel and door phases.
module elevator_ctrl #(
    parameter int FLOOR_TIME = 4,
    parameter int DOOR_TIME  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pressed_en,
    input  logic [1:0] pressed_lvl,
    output logic [1:0] cur_lvl,
    output logic       moving_up,
    output logic       moving_down,
    output logic       door_open,
    output logic [7:0] queue,
    output logic [2:0] tail,
    output logic       full
);
    typedef enum logic [1:0] {IDLE, UP, DOWN, DOOR} state_t;

    localparam logic [7:0] FLOOR_LAST = 8'(FLOOR_TIME - 1);
    localparam logic [7:0] DOOR_LAST  = 8'(DOOR_TIME - 1);

    state_t          state, state_nxt;
    logic [7:0]      timer;
    logic [3:0][1:0] q, q_nxt;
    logic [1:0]      head, next_lvl;
    logic [2:0]      wr_idx;
    logic            dup, direct, accept, pop;
    logic            traveling, step_last, can_step, arrive;

    assign head      = q[0];
    assign queue     = q;
    assign full      = (tail == 3'd4);
    assign traveling = (state == UP) || (state == DOWN);
    assign step_last = traveling && (timer == FLOOR_LAST);
    assign next_lvl  = (state == UP) ? cur_lvl + 2'd1 : cur_lvl - 2'd1;
    assign can_step  = ((state == UP) && (cur_lvl != 2'd3)) ||
                       ((state == DOWN) && (cur_lvl != 2'd0));
    assign arrive    = step_last && can_step && (tail != 3'd0) && (next_lvl == head);

    // Only live entries count as duplicates; this also drops a press for a head being popped.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < 4; i++)
            if ((3'(i) < tail) && (q[i] == pressed_lvl))
                dup = 1'b1;
    end

    assign direct = (state == IDLE) && (tail == 3'd0) && pressed_en && (pressed_lvl == cur_lvl);
    assign accept = pressed_en && !full && !dup && !direct &&
                    !((state == DOOR) && (pressed_lvl == cur_lvl));
    assign pop    = ((state == IDLE) && (tail != 3'd0) && (head == cur_lvl)) || arrive;
    assign wr_idx = tail - {2'b00, pop};

    always_comb begin
        q_nxt = pop ? {2'b00, q[3], q[2], q[1]} : q;
        if (accept)
            q_nxt[wr_idx[1:0]] = pressed_lvl;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (tail != 3'd0) begin
                    if (head > cur_lvl)      state_nxt = UP;
                    else if (head < cur_lvl) state_nxt = DOWN;
                    else                     state_nxt = DOOR;
                end else if (direct) begin
                    state_nxt = DOOR;
                end
            end
            UP, DOWN: begin
                if (arrive)                     state_nxt = DOOR;
                else if (step_last && !can_step) state_nxt = IDLE;
            end
            DOOR: if (timer == DOOR_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cur_lvl     <= 2'd0;
            q           <= '0;
            tail        <= 3'd0;
            timer       <= 8'd0;
            moving_up   <= 1'b0;
            moving_down <= 1'b0;
            door_open   <= 1'b0;
        end else begin
            state       <= state_nxt;
            q           <= q_nxt;
            tail        <= tail + {2'b00, accept} - {2'b00, pop};
            moving_up   <= (state_nxt == UP);
            moving_down <= (state_nxt == DOWN);
            door_open   <= (state_nxt == DOOR);
            if (step_last && can_step)
                cur_lvl <= next_lvl;
            if ((state_nxt != state) || step_last || (state == IDLE))
                timer <= 8'd0;
            else
                timer <= timer + 8'd1;
        end
    end
endmodule

// File: tb/tb_elevator_ctrl.sv
// Randomized and scenario bench for elevator_ctrl against a queue-based reference model.
module tb_elevator_ctrl;
    localparam int FT = 4;
    localparam int DT = 3;
    localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pressed_en = 1'b0;
    logic [1:0] pressed_lvl = 2'd0;
    logic [1:0] cur_lvl;
    logic       moving_up, moving_down, door_open;
    logic [7:0] queue;
    logic [2:0] tail;
    logic       full;

    int checks = 0;
    int errors = 0;

    // reference model: pending floors, car position, activity and cycles left in it
    int mq[$];
    int mcur = 0;
    int mmode = M_IDLE;
    int mleft = 0;

    elevator_ctrl #(.FLOOR_TIME(FT), .DOOR_TIME(DT)) dut (
        .clk(clk), .rst_n(rst_n), .pressed_en(pressed_en), .pressed_lvl(pressed_lvl),
        .cur_lvl(cur_lvl), .moving_up(moving_up), .moving_down(moving_down),
        .door_open(door_open), .queue(queue), .tail(tail), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_queue();
        int v = 0;
        foreach (mq[i]) v = v | (mq[i] << (2 * i));
        return v;
    endfunction

    function automatic int exp_flags();
        return (mmode == M_UP) ? 4 : (mmode == M_DOWN) ? 2 : (mmode == M_DOOR) ? 1 : 0;
    endfunction

    task automatic model_step(input bit en, input int lvl);
        bit dup = 0;
        bit pop = 0;
        bit direct, acc;
        foreach (mq[i]) if (mq[i] == lvl) dup = 1;
        direct = en && mmode == M_IDLE && mq.size() == 0 && lvl == mcur;
        acc = en && mq.size() < 4 && !dup && !direct && !(mmode == M_DOOR && lvl == mcur);
        case (mmode)
            M_IDLE: begin
                if (mq.size() > 0) begin
                    if (mq[0] > mcur) begin mmode = M_UP; mleft = FT; end
                    else if (mq[0] < mcur) begin mmode = M_DOWN; mleft = FT; end
                    else begin pop = 1; mmode = M_DOOR; mleft = DT; end
                end else if (direct) begin
                    mmode = M_DOOR; mleft = DT;
                end
            end
            M_UP, M_DOWN: begin
                mleft--;
                if (mleft == 0) begin
                    mcur = mcur + ((mmode == M_UP) ? 1 : -1);
                    mleft = FT;
                    if (mcur == mq[0]) begin pop = 1; mmode = M_DOOR; mleft = DT; end
                end
            end
            default: begin
                mleft--;
                if (mleft == 0) mmode = M_IDLE;
            end
        endcase
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(lvl);
    endtask

    always @(negedge rst_n) begin
        mq.delete();
        mcur = 0; mmode = M_IDLE; mleft = 0;
    end

    always @(posedge clk) if (rst_n) model_step(pressed_en, int'(pressed_lvl));

    always @(negedge clk) begin
        chk("cur_lvl", int'(cur_lvl), mcur);
        chk("up_down_door", int'({moving_up, moving_down, door_open}), exp_flags());
        chk("queue", int'(queue), exp_queue());
        chk("tail", int'(tail), mq.size());
        chk("full", int'(full), int'(mq.size() == 4));
    end

    task automatic drive(input bit en, input int lvl);
        @(negedge clk);
        pressed_en  = en;
        pressed_lvl = 2'(lvl);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        pressed_en = 1'b0;
        #1;
        chk("rst_cur", int'(cur_lvl), 0);
        chk("rst_flags", int'({moving_up, moving_down, door_open}), 0);
        chk("rst_queue", int'(queue), 0);
        chk("rst_tail", int'(tail), 0);
        chk("rst_full", int'(full), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int ups, doors, n;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // from reset: press D, 12 cycles up, 3 cycles of door, back to idle
        drive(1, 3);
        drive(0, 0);
        chk("d_tail", int'(tail), 1);
        chk("d_head", int'(queue[1:0]), 3);
        ups = 0; doors = 0;
        for (int i = 0; i < 25; i++) begin
            ups += int'(moving_up);
            doors += int'(door_open);
            drive(0, 0);
        end
        chk("d_up_cycles", ups, 12);
        chk("d_door_cycles", doors, 3);
        chk("d_final_lvl", int'(cur_lvl), 3);
        chk("d_final_tail", int'(tail), 0);

        // duplicate press while moving is dropped
        async_reset();
        drive(1, 3);
        drive(0, 0);
        drive(0, 0);
        drive(1, 1); drive(1, 2); drive(1, 1); drive(1, 3);
        drive(0, 0);
        chk("dup_tail", int'(tail), 3);
        chk("dup_queue", int'(queue), 8'b00_10_01_11);
        repeat (40) drive(0, 0);

        // fill all four floors, fifth press dropped
        async_reset();
        drive(1, 1); drive(1, 2); drive(1, 3); drive(1, 0);
        drive(1, 2);
        chk("fill_tail", int'(tail), 4);
        chk("fill_full", int'(full), 1);
        drive(0, 0);
        chk("fill_drop_tail", int'(tail), 4);
        chk("fill_drop_queue", int'(queue), 8'b00_11_10_01);
        repeat (60) drive(0, 0);

        // press at the current floor in idle opens the door directly
        async_reset();
        drive(1, 0);
        drive(0, 0);
        chk("direct_door", int'(door_open), 1);
        chk("direct_tail", int'(tail), 0);
        doors = 0;
        for (int i = 0; i < 6; i++) begin
            doors += int'(door_open);
            drive(0, 0);
        end
        chk("direct_door_cycles", doors, 3);

        // arrival at head C with C pressed the same cycle
        async_reset();
        drive(1, 2);
        drive(1, 0);
        n = 0;
        while (!(mmode == M_UP && mleft == 1 && mcur + 1 == 2) && n < 100) begin
            drive(0, 0);
            n++;
        end
        chk("arrive_found", int'(n < 100), 1);
        drive(1, 2);
        drive(0, 0);
        chk("arrive_lvl", int'(cur_lvl), 2);
        chk("arrive_door", int'(door_open), 1);
        chk("arrive_tail", int'(tail), 1);
        chk("arrive_queue", int'(queue), 0);
        repeat (30) drive(0, 0);

        // reset mid-trip between B and C, then normal service
        async_reset();
        drive(1, 2);
        n = 0;
        while (!(mmode == M_UP && mcur == 1) && n < 100) begin
            drive(0, 0);
            n++;
        end
        chk("midtrip_found", int'(n < 100), 1);
        drive(0, 0);
        async_reset();
        drive(1, 1);
        drive(0, 0);
        chk("resume_tail", int'(tail), 1);
        repeat (20) drive(0, 0);
        chk("resume_lvl", int'(cur_lvl), 1);

        // random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) async_reset();
            else drive($urandom_range(0, 2) == 0, $urandom_range(0, 3));
        end
        drive(0, 0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
